// File: rtl/keypad_pkg.sv
// Shared types, sizes and small combinational helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS  = 4;
    localparam int KP_COLS  = 4;
    localparam int KP_IDX_W = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // Active-low column drive: exactly one line low for the selected column.
    function automatic logic [KP_COLS-1:0] col_drive(input logic [KP_IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-index low row line wins when several rows are pulled down.
    function automatic logic [KP_IDX_W-1:0] row_prio(input logic [KP_ROWS-1:0] rs);
        logic [KP_IDX_W-1:0] idx;
        casez (rs)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler producing a one-clock tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic Clock,
    input  logic Resetn,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Prescaler count with registered wrap strobe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, debounce FSM and
// a one-cycle Valid strobe carrying {row_idx, col_idx} of each accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 16
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [KP_ROWS-1:0]          Rows,
    output logic [KP_COLS-1:0]          Cols,
    output logic [2*KP_IDX_W-1:0]       RowCol,
    output logic                        Valid,
    output logic                        KeyDown
);

    localparam int              DB_W     = $clog2(DEBOUNCE_TICKS + 2);
    localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_TICKS);

    logic                      tick_s;
    logic [KP_ROWS-1:0]        rows_meta_r;
    logic [KP_ROWS-1:0]        rs_r;
    kp_state_t                 state_r;
    logic [KP_IDX_W-1:0]       col_idx_r;
    logic [KP_IDX_W-1:0]       row_idx_r;
    logic [KP_ROWS-1:0]        pattern_r;
    logic [DB_W-1:0]           cnt_r;
    logic [DB_W-1:0]           rel_r;
    logic [KP_COLS-1:0]        cols_r;
    logic [2*KP_IDX_W-1:0]     rowcol_r;
    logic                      valid_r;
    logic                      keydown_r;
    logic [DB_W-1:0]           cnt_inc_s;
    logic [DB_W-1:0]           rel_inc_s;
    logic [KP_IDX_W-1:0]       row_sel_s;
    logic                      rows_idle_s;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .Clock  (Clock),
        .Resetn (Resetn),
        .tick   (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row lines; idle is all-high.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rows_meta_r <= 4'hF;
            rs_r        <= 4'hF;
        end else begin
            rows_meta_r <= Rows;
            rs_r        <= rows_meta_r;
        end
    end

    // Counter increments and row priority decode feeding the FSM.
    always_comb begin
        cnt_inc_s   = cnt_r + DB_W'(1);
        rel_inc_s   = rel_r + DB_W'(1);
        row_sel_s   = row_prio(rs_r);
        rows_idle_s = (rs_r == 4'hF);
    end

    // Scan / debounce / hold state machine; all decisions taken on scan ticks.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= SCAN;
            col_idx_r <= 2'd0;
            row_idx_r <= 2'd0;
            pattern_r <= 4'hF;
            cnt_r     <= '0;
            rel_r     <= '0;
            cols_r    <= 4'b1110;
            rowcol_r  <= 4'h0;
            valid_r   <= 1'b0;
            keydown_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (tick_s) begin
                case (state_r)
                    SCAN: begin
                        if (rows_idle_s) begin
                            col_idx_r <= col_idx_r + 2'd1;
                            cols_r    <= col_drive(col_idx_r + 2'd1);
                        end else begin
                            row_idx_r <= row_sel_s;
                            pattern_r <= rs_r;
                            cnt_r     <= DB_W'(1);
                            state_r   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs_r == pattern_r) begin
                            if (cnt_inc_s >= DB_LIMIT) begin
                                rowcol_r  <= {row_idx_r, col_idx_r};
                                valid_r   <= 1'b1;
                                keydown_r <= 1'b1;
                                cnt_r     <= '0;
                                rel_r     <= '0;
                                state_r   <= HELD;
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end else begin
                            // Bounce or key change: restart detection on the same column.
                            cnt_r   <= '0;
                            state_r <= SCAN;
                        end
                    end
                    HELD: begin
                        if (rows_idle_s) begin
                            if (rel_inc_s >= DB_LIMIT) begin
                                keydown_r <= 1'b0;
                                rel_r     <= '0;
                                col_idx_r <= col_idx_r + 2'd1;
                                cols_r    <= col_drive(col_idx_r + 2'd1);
                                state_r   <= SCAN;
                            end else begin
                                rel_r <= rel_inc_s;
                            end
                        end else begin
                            rel_r <= '0;
                        end
                    end
                    default: begin
                        state_r <= SCAN;
                        cnt_r   <= '0;
                        rel_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign Cols    = cols_r;
    assign RowCol  = rowcol_r;
    assign Valid   = valid_r;
    assign KeyDown = keydown_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    logic        Clock;
    logic        Resetn;
    logic [3:0]  Rows;
    logic [3:0]  Cols;
    logic [3:0]  RowCol;
    logic        Valid;
    logic        KeyDown;

    logic [15:0] keys;       // bit r*4+c = key (r,c) pressed
    int          vcount;
    int          n_cmp;
    int          n_bad;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .CNT_W          (16)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Rows    (Rows),
        .Cols    (Cols),
        .RowCol  (RowCol),
        .Valid   (Valid),
        .KeyDown (KeyDown)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Key matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        Rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !Cols[c]) Rows[r] = 1'b0;
            end
        end
    end

    always @(posedge Clock) begin
        if (Valid === 1'b1) vcount <= vcount + 1;
    end

    typedef struct {
        logic [15:0] keys;
        int          clocks;
        int          exp_valids;
        logic [3:0]  exp_rowcol;
        logic        exp_keydown;
        logic        chk_cols;
        logic [3:0]  exp_cols;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        int base;
        base = vcount;
        keys = vecs[i].keys;
        repeat (vecs[i].clocks) @(negedge Clock);
        check($sformatf("vec%0d valids", i), 32'(vcount - base), 32'(vecs[i].exp_valids));
        check($sformatf("vec%0d rowcol", i), {28'd0, RowCol}, {28'd0, vecs[i].exp_rowcol});
        check($sformatf("vec%0d keydown", i), {31'd0, KeyDown}, {31'd0, vecs[i].exp_keydown});
        if (vecs[i].chk_cols)
            check($sformatf("vec%0d cols", i), {28'd0, Cols}, {28'd0, vecs[i].exp_cols});
    endtask

    // Release every key, wait for KeyDown to fall and check where scanning resumes.
    task automatic release_keys(input string name, input logic [3:0] exp_cols);
        int base;
        int n;
        base = vcount;
        keys = 16'h0000;
        n    = 0;
        while (KeyDown === 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check({name, " keydown_fall"}, {31'd0, KeyDown}, 32'd0);
        check({name, " release_latency"}, {31'd0, (n >= 9 && n <= 18)}, 32'd1);
        check({name, " resume_cols"}, {28'd0, Cols}, {28'd0, exp_cols});
        check({name, " no_valid"}, 32'(vcount - base), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " cols"}, {28'd0, Cols}, 32'h0000_000E);
        check({name, " rowcol"}, {28'd0, RowCol}, 32'd0);
        check({name, " valid"}, {31'd0, Valid}, 32'd0);
        check({name, " keydown"}, {31'd0, KeyDown}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_seq [5];
        logic [3:0] cur;
        int         n;
        int         base;

        vecs[0] = '{16'h0200, 60, 1, 4'b1001, 1'b1, 1'b1, 4'b1101};
        vecs[1] = '{16'h0200, 40, 0, 4'b1001, 1'b1, 1'b1, 4'b1101};
        vecs[2] = '{16'h1010, 60, 1, 4'b0100, 1'b1, 1'b1, 4'b1110};
        vecs[3] = '{16'h1014, 40, 0, 4'b0100, 1'b1, 1'b1, 4'b1110};
        exp_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

        n_cmp  = 0;
        n_bad  = 0;
        vcount = 0;
        keys   = 16'h0000;
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_values("reset");
        Resetn = 1'b1;

        // Idle sweep: each column held for exactly SCAN_DIV clocks.
        n   = 0;
        cur = Cols;
        while (Cols === cur && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("idle first_change", {31'd0, (n < 20)}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("idle cols%0d", k), {28'd0, Cols}, {28'd0, exp_seq[k]});
            cur = Cols;
            n   = 0;
            do begin
                @(negedge Clock);
                n++;
            end while (Cols === cur && n < 20);
            check($sformatf("idle dwell%0d", k), 32'(n), 32'd4);
        end
        check("idle no_valid", 32'(vcount), 32'd0);
        check("idle rowcol", {28'd0, RowCol}, 32'd0);

        // Steady press of (2,1), then held.
        apply_vec(0);
        apply_vec(1);
        release_keys("rel21", 4'b1011);

        // Bouncing (0,3): no accept while toggling every 5 clocks.
        base = vcount;
        for (int p = 0; p < 8; p++) begin
            keys = (p % 2 == 0) ? 16'h0008 : 16'h0000;
            repeat (5) @(negedge Clock);
        end
        check("bounce no_valid", 32'(vcount - base), 32'd0);
        keys = 16'h0008;
        repeat (60) @(negedge Clock);
        check("bounce one_valid", 32'(vcount - base), 32'd1);
        check("bounce rowcol", {28'd0, RowCol}, 32'h0000_0003);
        check("bounce keydown", {31'd0, KeyDown}, 32'd1);
        release_keys("rel03", 4'b1110);

        // Two keys in one column resolve by priority; other column ignored while held.
        apply_vec(2);
        apply_vec(3);
        release_keys("rel10", 4'b1101);

        // Reset during DEBOUNCE of key (1,2).
        base = vcount;
        keys = 16'h0040;
        n    = 0;
        while (Cols !== 4'b1011 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        check("rst_db col_wait", {31'd0, (n < 40)}, 32'd1);
        repeat (6) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check_reset_values("rst_db");
        check("rst_db no_valid", 32'(vcount - base), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        base = vcount;
        repeat (60) @(negedge Clock);
        check("redetect1 valids", 32'(vcount - base), 32'd1);
        check("redetect1 rowcol", {28'd0, RowCol}, 32'h0000_0006);
        check("redetect1 keydown", {31'd0, KeyDown}, 32'd1);
        check("redetect1 cols", {28'd0, Cols}, 32'h0000_000B);

        // Reset while HELD.
        base   = vcount;
        Resetn = 1'b0;
        #1;
        check_reset_values("rst_held");
        repeat (2) @(negedge Clock);
        check("rst_held no_valid", 32'(vcount - base), 32'd0);
        Resetn = 1'b1;
        repeat (60) @(negedge Clock);
        check("redetect2 valids", 32'(vcount - base), 32'd1);
        check("redetect2 rowcol", {28'd0, RowCol}, 32'h0000_0006);
        release_keys("rel12", 4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
